fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer.sv | 99 +++++++++
 tb/tb_fetch_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch control bus between the program sequencer and its decoder/ROM side.
// The slave modport is the sequencer; the master modport drives launch and decode flags.
interface fetch_sequencer_if #(
  parameter int IW = 9
);
  logic          Start;
  logic          Halt;
  logic          BranchEn;
  logic          BranchRel;
  logic [IW-1:0] Target;
  logic [IW-1:0] InstAddress;
  logic          Busy;
  logic          Done;
  logic [15:0]   CycleCount;

  modport slave (
    input  Start, Halt, BranchEn, BranchRel, Target,
    output InstAddress, Busy, Done, CycleCount
  );

  modport master (
    output Start, Halt, BranchEn, BranchRel, Target,
    input  InstAddress, Busy, Done, CycleCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/RUN/DONE program-counter control with branch and halt.
// Optional run-cycle counter enabled by macro FETCH_CYCLE_COUNT_EN (otherwise CycleCount is 0).
//
// state | meaning
// IDLE  | waiting for Start, fetch address parked at START_ADDR
// RUN   | fetching; address advances, branches or halts each cycle
// DONE  | program halted, address held at the halt instruction
module fetch_sequencer #(
  parameter int          IW         = 9,
  parameter logic [IW-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [IW-1:0] r_addr;
  logic [IW-1:0] w_next_addr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_addr  <= START_ADDR;
    end else begin
      r_state <= w_next_state;
      r_addr  <= w_next_addr;
    end
  end

  // Address arithmetic wraps naturally at IW bits for both sequential and relative steps.
  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_addr;
    case (r_state)
      S_IDLE: begin
        w_next_addr = START_ADDR;
        if (bus.Start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (bus.Halt) begin
          w_next_state = S_DONE;
        end else if (bus.BranchEn && bus.BranchRel) begin
          w_next_addr = r_addr + bus.Target;
        end else if (bus.BranchEn) begin
          w_next_addr = bus.Target;
        end else begin
          w_next_addr = r_addr + IW'(1);
        end
      end
      S_DONE: begin
        if (bus.Start) begin
          w_next_state = S_RUN;
          w_next_addr  = START_ADDR;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_addr  = START_ADDR;
      end
    endcase
  end

  assign bus.InstAddress = r_addr;
  assign bus.Busy        = (r_state == S_RUN);
  assign bus.Done        = (r_state == S_DONE);

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] r_cycle_count;
  logic        w_run_entry;
  logic        w_run_stay;

  assign w_run_entry = (r_state != S_RUN) && (w_next_state == S_RUN);
  assign w_run_stay  = (r_state == S_RUN) && (w_next_state == S_RUN);

  // Counts RUN cycles including the first; the halting cycle is already counted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cycle_count <= 16'd0;
    end else if (w_run_entry) begin
      r_cycle_count <= 16'd1;
    end else if (w_run_stay && (r_cycle_count != 16'hFFFF)) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign bus.CycleCount = r_cycle_count;
`else
  assign bus.CycleCount = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed steps queue their expected post-edge outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_fetch_sequencer;
  localparam int IW = 9;

  typedef struct {
    int          id;
    logic [8:0]  addr;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  fetch_sequencer_if #(.IW(IW)) bus ();

  fetch_sequencer #(.IW(IW), .START_ADDR(9'h000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  exp_t q[$];

  function automatic logic [15:0] cc(input int n);
`ifdef FETCH_CYCLE_COUNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic h, input logic be,
                      input logic br, input logic [8:0] tgt,
                      input logic [8:0] ea, input logic eb, input logic ed, input int n);
    exp_t e;
    @(negedge Clk);
    Reset         = rst;
    bus.Start     = st;
    bus.Halt      = h;
    bus.BranchEn  = be;
    bus.BranchRel = br;
    bus.Target    = tgt;
    step_no++;
    e.id   = step_no;
    e.addr = ea;
    e.busy = eb;
    e.done = ed;
    e.cnt  = cc(n);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("addr", e.id, 16'(bus.InstAddress), 16'(e.addr));
        chk("busy", e.id, 16'(bus.Busy), 16'(e.busy));
        chk("done", e.id, 16'(bus.Done), 16'(e.done));
        chk("cycle_count", e.id, bus.CycleCount, e.cnt);
      end
    end
  end

  initial begin : stimulus
    bus.Start     = 1'b0;
    bus.Halt      = 1'b0;
    bus.BranchEn  = 1'b0;
    bus.BranchRel = 1'b0;
    bus.Target    = '0;

    // reset wins over Start
    step(1, 1, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);
    step(1, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);
    // launch, then sequential fetch up to 0x010
    step(0, 1, 0, 0, 0, 9'h000, 9'h000, 1, 0, 1);
    for (int k = 1; k <= 16; k++) step(0, 0, 0, 0, 0, 9'h000, 9'(k), 1, 0, k + 1);
    // relative -4 from 0x010, absolute to 0x100, absolute to 0x1FF, then wrap
    step(0, 0, 0, 1, 1, 9'h1FC, 9'h00C, 1, 0, 18);
    step(0, 0, 0, 1, 0, 9'h100, 9'h100, 1, 0, 19);
    step(0, 0, 0, 1, 0, 9'h1FF, 9'h1FF, 1, 0, 20);
    step(0, 0, 0, 0, 0, 9'h000, 9'h000, 1, 0, 21);
    // Start ignored while running
    step(0, 1, 0, 0, 0, 9'h000, 9'h001, 1, 0, 22);
    step(0, 0, 0, 1, 0, 9'h055, 9'h055, 1, 0, 23);
    // reset mid-run aborts
    step(1, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);
    // decode flags ignored in IDLE
    step(0, 0, 1, 1, 0, 9'h077, 9'h000, 0, 0, 0);
    step(0, 1, 0, 0, 0, 9'h000, 9'h000, 1, 0, 1);
    for (int k = 1; k <= 32; k++) step(0, 0, 0, 0, 0, 9'h000, 9'(k), 1, 0, k + 1);
    // halt beats branch at 0x020
    step(0, 0, 1, 1, 0, 9'h100, 9'h020, 0, 1, 33);
    step(0, 0, 1, 1, 1, 9'h050, 9'h020, 0, 1, 33);
    // relaunch from DONE
    step(0, 1, 0, 0, 0, 9'h000, 9'h000, 1, 0, 1);
    step(0, 0, 0, 1, 1, 9'h1FF, 9'h1FF, 1, 0, 2);
    step(0, 0, 1, 0, 0, 9'h000, 9'h1FF, 0, 1, 2);
    step(0, 0, 0, 0, 0, 9'h000, 9'h1FF, 0, 1, 2);
    step(1, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);

    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
